// File: rtl/prog_loader_pkg.sv
// Shared types and defaults for the serial-loadable program store.
// Default geometry matches the 4-bit accumulator core (16 x 8-bit instructions).
package prog_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_e;

  localparam int DEF_DEPTH = 16;
  localparam int DEF_AW    = 4;
  localparam int DEF_DW    = 8;
  localparam int DEF_NSYNC = 2;

  localparam logic [7:0] NOP_INSTR = 8'h00;

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for one asynchronous load-port pin.
// RST_VAL lets the frame select come out of reset at its idle-high level.
module sync_bit #(
  parameter int   NSYNC   = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [NSYNC-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {NSYNC{RST_VAL}};
    end else begin
      sync_q <= {sync_q[NSYNC-2:0], d_i};
    end
  end

  assign q_o = sync_q[NSYNC-1];

endmodule

// File: rtl/prog_loader.sv
// Loadable program store: receives a program over SCK/SDI/CSN, writes it to RAM,
// and serves instructions to the core once a complete, non-empty program is present.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW,
  parameter int NSYNC = DEF_NSYNC
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_sck,
  input  logic          ld_sdi,
  input  logic          ld_csn,
  input  logic [AW-1:0] fetch_addr,
  output logic [DW-1:0] fetch_instr,
  output logic          run,
  output logic [AW-1:0] last_addr,
  output logic          busy,
  output logic          err
);

  logic sckSync, sdiSync, csnSync;
  logic sckPrev_q, csnPrev_q;
  logic sckRise, csnFall, csnRise;

  sync_bit #(.NSYNC(NSYNC), .RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst(rst), .d_i(ld_sck), .q_o(sckSync));
  sync_bit #(.NSYNC(NSYNC), .RST_VAL(1'b0)) u_sync_sdi (
    .clk(clk), .rst(rst), .d_i(ld_sdi), .q_o(sdiSync));
  sync_bit #(.NSYNC(NSYNC), .RST_VAL(1'b1)) u_sync_csn (
    .clk(clk), .rst(rst), .d_i(ld_csn), .q_o(csnSync));

  assign sckRise = sckSync & ~sckPrev_q;
  assign csnFall = ~csnSync & csnPrev_q;
  assign csnRise = csnSync & ~csnPrev_q;

  state_e        state_q, state_d;
  logic          run_q, run_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic [AW-1:0] lastAddr_q, lastAddr_d;
  logic [AW:0]   wptr_q, wptr_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [DW-2:0] shreg_q, shreg_d;
  logic [DW-1:0] newByte;
  logic          memWe;

  logic [DW-1:0] mem [DEPTH];

  assign newByte = {shreg_q, sdiSync};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      run_q      <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      lastAddr_q <= '0;
      wptr_q     <= '0;
      bitcnt_q   <= '0;
      shreg_q    <= '0;
      sckPrev_q  <= 1'b0;
      csnPrev_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      lastAddr_q <= lastAddr_d;
      wptr_q     <= wptr_d;
      bitcnt_q   <= bitcnt_d;
      shreg_q    <= shreg_d;
      sckPrev_q  <= sckSync;
      csnPrev_q  <= csnSync;
    end
  end

  // In LOAD the sck edge is applied before a coinciding csn rise, so a byte
  // finishing on the closing edge is still counted in last_addr.
  always_comb begin
    state_d    = state_q;
    run_d      = run_q;
    busy_d     = busy_q;
    err_d      = err_q;
    lastAddr_d = lastAddr_q;
    wptr_d     = wptr_q;
    bitcnt_d   = bitcnt_q;
    shreg_d    = shreg_q;
    memWe      = 1'b0;

    case (state_q)
      IDLE, RUN: begin
        if (csnFall) begin
          state_d  = LOAD;
          run_d    = 1'b0;
          busy_d   = 1'b1;
          err_d    = 1'b0;
          wptr_d   = '0;
          bitcnt_d = '0;
        end
      end
      LOAD: begin
        if (sckRise) begin
          shreg_d  = newByte[DW-2:0];
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            if (wptr_q == (AW+1)'(DEPTH)) begin
              err_d = 1'b1;
            end else begin
              memWe  = 1'b1;
              wptr_d = wptr_q + (AW+1)'(1);
            end
          end
        end
        if (csnRise) begin
          busy_d = 1'b0;
          if (bitcnt_d != 3'd0) begin
            err_d = 1'b1;
          end
          if (wptr_d == '0) begin
            state_d = IDLE;
            run_d   = 1'b0;
          end else begin
            state_d    = RUN;
            run_d      = 1'b1;
            lastAddr_d = AW'(wptr_d - (AW+1)'(1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[wptr_q[AW-1:0]] <= newByte;
    end
  end

  assign fetch_instr = run_q ? mem[fetch_addr] : DW'(NOP_INSTR);
  assign run         = run_q;
  assign busy        = busy_q;
  assign err         = err_q;
  assign last_addr   = lastAddr_q;

endmodule
